// File: rtl/field_select_arbiter.sv
// Round-robin shared part-select extractor over an ascending-range word register.
// Latency 1 into a 1-deep result slot. Optional counters under FSEL_STATS_EN.
module field_select_arbiter #(
   parameter int NREQ   = 4,
   parameter int WORD_W = 32,
   parameter int LO     = 19,
   parameter int FLD_W  = 4,
   parameter int OFF_W  = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      word_ld,
   input  logic [WORD_W-1:0]         word_i,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*OFF_W-1:0]     req_off,
   input  logic [NREQ-1:0]           req_dir,
   output logic [NREQ-1:0]           req_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [FLD_W-1:0]          out_data,
   output logic [$clog2(NREQ)-1:0]   out_id,
   output logic                      out_oob
`ifdef FSEL_STATS_EN
   ,
   output logic [15:0]               stat_grants,
   output logic [15:0]               stat_oob
`endif
);

   localparam int IDW = $clog2(NREQ);
   // One bit beyond OFF_W+8 so descending selects below index 0 stay signed-safe.
   localparam int IW  = OFF_W + 9;

   logic [LO:LO+WORD_W-1]   r_word;
   logic                    r_out_valid;
   logic [FLD_W-1:0]        r_out_data;
   logic [IDW-1:0]          r_out_id;
   logic                    r_out_oob;
   logic [IDW-1:0]          r_rr;

   logic                    w_slot_free;
   logic                    w_any;
   logic [IDW-1:0]          w_gnt_id;
   logic [NREQ-1:0]         w_gnt;
   logic                    w_accept;
   logic [OFF_W-1:0]        w_off;
   logic                    w_dir;
   logic signed [IW-1:0]    w_idx;
   logic signed [IW-1:0]    w_base;
   logic signed [IW-1:0]    w_k;
   logic [WORD_W-1:0]       w_rev;
   logic [WORD_W-1:0]       w_sh;
   logic [FLD_W-1:0]        w_fld;
   logic                    w_oob;

   assign w_slot_free = !r_out_valid || out_ready;

   always_comb begin
      w_any    = 1'b0;
      w_gnt_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         automatic int c = (int'(r_rr) + i) % NREQ;
         if (!w_any && req_valid[c]) begin
            w_any    = 1'b1;
            w_gnt_id = IDW'(c);
         end
      end
      if (!(rst_n && w_slot_free)) w_any = 1'b0;
      w_gnt = w_any ? (NREQ'(1) << w_gnt_id) : '0;
   end

   assign req_ready = w_gnt;
   assign w_accept  = |(req_valid & w_gnt);

   // w_rev[p] is the bit at index LO+p, so offsets from LO index it directly.
   always_comb begin
      w_rev = '0;
      for (int p = 0; p < WORD_W; p++) w_rev[p] = r_word[LO+p];
   end

   always_comb begin
      w_off  = req_off[w_gnt_id*OFF_W +: OFF_W];
      w_dir  = req_dir[w_gnt_id];
      w_idx  = IW'(LO) + IW'(w_off);
      w_base = w_dir ? (w_idx - IW'(FLD_W-1)) : w_idx;
      w_fld  = '0;
      w_oob  = 1'b0;
      w_k    = '0;
      w_sh   = '0;
      for (int j = 0; j < FLD_W; j++) begin
         w_k = w_base + IW'(j);
         if ((w_k < IW'(LO)) || (w_k > IW'(LO+WORD_W-1))) begin
            w_oob = 1'b1;
         end else begin
            w_sh = w_rev >> (w_k - IW'(LO));
            w_fld[FLD_W-1-j] = w_sh[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_word      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
         r_out_oob   <= 1'b0;
         r_rr        <= '0;
      end else begin
         if (word_ld) r_word <= word_i;
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_fld;
            r_out_id    <= w_gnt_id;
            r_out_oob   <= w_oob;
            r_rr        <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;
   assign out_oob   = r_out_oob;

`ifdef FSEL_STATS_EN
   logic [15:0] r_stat_grants;
   logic [15:0] r_stat_oob;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_grants <= '0;
         r_stat_oob    <= '0;
      end else if (w_accept) begin
         if (r_stat_grants != 16'hFFFF) r_stat_grants <= r_stat_grants + 16'd1;
         if (w_oob && (r_stat_oob != 16'hFFFF)) r_stat_oob <= r_stat_oob + 16'd1;
      end
   end

   assign stat_grants = r_stat_grants;
   assign stat_oob    = r_stat_oob;
`endif

endmodule

// File: tb/tb_field_select_arbiter.sv
// Bench for field_select_arbiter: directed scenarios then random traffic against a bit-level reference model.
module tb_field_select_arbiter;
   localparam int NREQ = 4, WORD_W = 32, LO = 19, FLD_W = 4, OFF_W = 6, IDW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n, word_ld, out_ready;
   logic [WORD_W-1:0]     word_i;
   logic [NREQ-1:0]       req_valid, req_dir, req_ready;
   logic [NREQ*OFF_W-1:0] req_off;
   logic                  out_valid, out_oob;
   logic [FLD_W-1:0]      out_data;
   logic [IDW-1:0]        out_id;
`ifdef FSEL_STATS_EN
   logic [15:0]           stat_grants, stat_oob;
`endif

   field_select_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .LO(LO), .FLD_W(FLD_W), .OFF_W(OFF_W)) dut (
      .clk(clk), .rst_n(rst_n), .word_ld(word_ld), .word_i(word_i),
      .req_valid(req_valid), .req_off(req_off), .req_dir(req_dir), .req_ready(req_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .out_oob(out_oob)
`ifdef FSEL_STATS_EN
      , .stat_grants(stat_grants), .stat_oob(stat_oob)
`endif
   );

   int total = 0, bad = 0;
   logic [WORD_W-1:0] m_word;
   logic              m_ov, m_oob;
   logic [FLD_W-1:0]  m_od;
   int                m_oid, m_rr, m_sg, m_so, last_gnt;
   logic [FLD_W-1:0]  held;

   // Field from the index rules: bit k lives at word[WORD_W-1-(k-LO)], lowest index first.
   function automatic void ref_field(input logic [WORD_W-1:0] w, input int off, input bit dir,
                                     output logic [FLD_W-1:0] d, output logic oob);
      int first, k;
      first = dir ? (LO + off - FLD_W + 1) : (LO + off);
      d = '0;
      oob = 1'b0;
      for (int j = 0; j < FLD_W; j++) begin
         k = first + j;
         d = d << 1;
         if (k < LO || k > LO + WORD_W - 1) oob = 1'b1;
         else d[0] = w[WORD_W-1-(k-LO)];
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input int off, input logic dir);
      req_valid[r] = v;
      req_off[r*OFF_W +: OFF_W] = OFF_W'(off);
      req_dir[r] = dir;
   endtask

   // One clock: check the combinational grant, clock it, advance the model, check the registers.
   task automatic cycle();
      int g;
      logic [FLD_W-1:0] d;
      logic o;
      #1;
      g = -1;
      if (rst_n && (!m_ov || out_ready))
         for (int i = 0; i < NREQ; i++)
            if (g < 0 && req_valid[(m_rr + i) % NREQ]) g = (m_rr + i) % NREQ;
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      last_gnt = g;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_word = '0; m_ov = 1'b0; m_od = '0; m_oid = 0; m_oob = 1'b0; m_rr = 0; m_sg = 0; m_so = 0;
      end else begin
         if (g >= 0) begin
            ref_field(m_word, int'(req_off[g*OFF_W +: OFF_W]), req_dir[g], d, o);
            m_ov = 1'b1; m_od = d; m_oid = g; m_oob = o; m_rr = (g + 1) % NREQ;
            if (m_sg < 65535) m_sg++;
            if (o && m_so < 65535) m_so++;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (word_ld) m_word = word_i;
      end
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_id", 32'(out_id), 32'(m_oid));
      chk("out_oob", 32'(out_oob), 32'(m_oob));
`ifdef FSEL_STATS_EN
      chk("stat_grants", 32'(stat_grants), 32'(m_sg));
      chk("stat_oob", 32'(stat_oob), 32'(m_so));
`endif
   endtask

   task automatic single(input int off, input logic dir, input logic [3:0] exp_d, input logic exp_o, input string tag);
      set_req(0, 1'b1, off, dir);
      cycle();
      req_valid = '0;
      chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
      chk({tag, "_oob"}, 32'(out_oob), 32'(exp_o));
      chk({tag, "_id"}, 32'(out_id), 32'd0);
   endtask

   initial begin
      m_ov = 1'b0; m_rr = 0; m_word = '0; m_od = '0; m_oid = 0; m_oob = 1'b0; m_sg = 0; m_so = 0;
      rst_n = 1'b0; word_ld = 1'b0; word_i = '0; out_ready = 1'b1;
      req_valid = 4'hF; req_off = '0; req_dir = '0;
      cycle();
      cycle();
      chk("rst_valid", 32'(out_valid), 32'd0);

      // Path clearing
      rst_n = 1'b1; req_valid = '0; word_i = 32'h12345678; word_ld = 1'b1;
      cycle();
      word_ld = 1'b0;
      single(8, 1'b0, 4'h3, 1'b0, "p_off8_asc");
      single(7, 1'b1, 4'h2, 1'b0, "p_off7_desc");
      single(28, 1'b0, 4'h8, 1'b0, "p_off28_asc");

      // Boundary
      word_i = 32'h80000001; word_ld = 1'b1;
      cycle();
      word_ld = 1'b0;
      single(1, 1'b1, 4'h2, 1'b1, "b_off1_desc");
      single(31, 1'b0, 4'h8, 1'b1, "b_off31_asc");
      single(40, 1'b0, 4'h0, 1'b1, "b_off40_asc");

      // Round-robin from a fresh pointer
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, r * 3, r[0]);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_gnt", 32'(req_ready), 32'd1 << (i % NREQ));
         cycle();
         chk("rr_id", 32'(out_id), 32'(i % NREQ));
      end

      // Backpressure: slot full and not drained blocks every grant
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'(held));
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_gnt", 32'(req_ready), 32'b0100);
      cycle();
      req_valid = '0;

      // word_ld colliding with acceptance uses the old word
      word_i = 32'h12345678; word_ld = 1'b1;
      cycle();
      word_i = 32'hFFFFFFFF;
      single(0, 1'b0, 4'h1, 1'b0, "hz_old");
      word_ld = 1'b0;
      single(0, 1'b0, 4'hF, 1'b0, "hz_new");

      // Reset while a result is pending
      out_ready = 1'b0;
      set_req(2, 1'b1, 5, 1'b0);
      cycle();
      req_valid = '0;
      chk("mid_pending", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      cycle();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1; out_ready = 1'b1; req_valid = 4'hF;
      #1;
      chk("mid_first_gnt", 32'(req_ready), 32'd1);
      cycle();

      // Random traffic; a waiting requester keeps its request unchanged
      for (int n = 0; n < 600; n++) begin
         for (int r = 0; r < NREQ; r++)
            if (!(req_valid[r] && last_gnt != r && rst_n))
               set_req(r, ($urandom_range(0, 9) < 6), $urandom_range(0, 63), $urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         word_ld   = ($urandom_range(0, 4) == 0);
         word_i    = $urandom;
         rst_n     = ($urandom_range(0, 49) != 0);
         cycle();
      end
      rst_n = 1'b1; word_ld = 1'b0;

`ifdef FSEL_STATS_EN
      out_ready = 1'b1; req_valid = 4'h1;
      for (int n = 0; n < 65540; n++) cycle();
      chk("stat_sat", 32'(stat_grants), 32'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
